mor1kx_trace_capture_ctrl: RTL and testbench

Trace capture sequencer that sits on the mor1kx execute traceport next to the simulation monitor. Arms on request, opens a capture window on the l.nop 0x64 marker and closes it on the l.nop 0xc8 marker, on exit, or on a record limit. Retired-instruction records go into an internal FIFO, which drains to a trace sink over a valid/ready handshake. Sequential controller with counters and buffering, not a monitor.

---
 rtl/mor1kx_trace_capture_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mor1kx_trace_capture_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_trace_capture_ctrl.sv
// ---------------------------------------------------------------------------
// mor1kx_trace_capture_ctrl
//
// Trace capture sequencer on the mor1kx execute traceport. Once armed, it waits
// for the l.nop 0x64 marker to open a capture window. While the window is open,
// each retired instruction is written as a record into an internal
// first-word-fall-through FIFO. The window closes on any of these events:
//   - the l.nop 0xc8 marker,
//   - an exit l.nop,
//   - reaching the record limit.
// The FIFO drains to a trace sink over a valid/ready handshake in every state.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   traceport_exec_*         retired-instruction traceport (valid, pc, insn,
//                            wbdata, wbreg, wben)
//   arm, capture_limit       arm request (IDLE only) and per-window record
//                            limit (0 = unlimited), latched on accepted arm
//   rec_valid, rec_ready     record handshake to the trace sink
//   rec_pc .. rec_wben       head-of-FIFO record, zero while the FIFO is empty
//   state                    registered state: 0 IDLE, 1 ARMED, 2 CAPTURE,
//                            3 DRAIN
//   done                     window finished and FIFO empty; sticky until the
//                            next accepted arm
//   captured_count           records pushed this window (saturating)
//   overflow_count           records dropped on a full FIFO (saturating)
// ---------------------------------------------------------------------------
module mor1kx_trace_capture_ctrl #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH_LOG2      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            traceport_exec_valid,
  input  logic [31:0]                     traceport_exec_pc,
  input  logic [31:0]                     traceport_exec_insn,
  input  logic [OPTION_OPERAND_WIDTH-1:0] traceport_exec_wbdata,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] traceport_exec_wbreg,
  input  logic                            traceport_exec_wben,
  input  logic                            arm,
  input  logic [15:0]                     capture_limit,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic [31:0]                     rec_pc,
  output logic [31:0]                     rec_insn,
  output logic [OPTION_OPERAND_WIDTH-1:0] rec_wbdata,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rec_wbreg,
  output logic                            rec_wben,
  output logic [1:0]                      state,
  output logic                            done,
  output logic [15:0]                     captured_count,
  output logic [15:0]                     overflow_count
);

  localparam logic [31:0] INSN_START = 32'h1500_0064;
  localparam logic [31:0] INSN_STOP  = 32'h1500_00c8;
  localparam logic [31:0] INSN_EXIT0 = 32'h1500_0001;
  localparam logic [31:0] INSN_EXIT1 = 32'h1500_000c;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]                     pc;
    logic [31:0]                     insn;
    logic [OPTION_OPERAND_WIDTH-1:0] wbdata;
    logic [OPTION_RF_ADDR_WIDTH-1:0] wbreg;
    logic                            wben;
  } record_t;

  state_t state_q, state_d;

  // Marker decode, qualified by a valid retirement.
  logic is_start, is_stop, is_exit;
  assign is_start = traceport_exec_valid && (traceport_exec_insn == INSN_START);
  assign is_stop  = traceport_exec_valid && (traceport_exec_insn == INSN_STOP);
  assign is_exit  = traceport_exec_valid &&
                    ((traceport_exec_insn == INSN_EXIT0) ||
                     (traceport_exec_insn == INSN_EXIT1));

  logic arm_accept;
  assign arm_accept = arm && (state_q == ST_IDLE);

  // -------------------------------------------------------------------------
  // Record FIFO. The pointers carry one extra wrap bit so that full and empty
  // can be told apart without a separate occupancy counter.
  // -------------------------------------------------------------------------
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  record_t                    mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic                       fifo_empty, fifo_full;
  logic                       push_req, push_ok, push_drop, pop;
  record_t                    wr_rec, head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                      (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);

  assign pop       = rec_valid && rec_ready;
  assign push_req  = (state_q == ST_CAPTURE) && traceport_exec_valid && !is_stop;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign push_drop = push_req && fifo_full && !pop;

  assign wr_rec = '{pc:     traceport_exec_pc,
                    insn:   traceport_exec_insn,
                    wbdata: traceport_exec_wbdata,
                    wbreg:  traceport_exec_wbreg,
                    wben:   traceport_exec_wben};

  // NOTE: the storage array has no reset; flushing is done by resetting the
  // pointers, and the output mux below hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= wr_rec;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Reading from registered pointers only: a push into an empty FIFO becomes
  // visible one cycle later, never in the same cycle.
  assign rec_valid = !fifo_empty;
  assign head      = fifo_empty ? record_t'('0) : mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  assign rec_pc     = head.pc;
  assign rec_insn   = head.insn;
  assign rec_wbdata = head.wbdata;
  assign rec_wbreg  = head.wbreg;
  assign rec_wben   = head.wben;

  // -------------------------------------------------------------------------
  // Counters, limit and done flag
  // -------------------------------------------------------------------------
  logic [15:0] limit_q;
  logic [15:0] captured_inc;
  logic        limit_hit;

  assign captured_inc = (captured_count == 16'hFFFF) ? captured_count
                                                     : captured_count + 16'd1;
  // Only accepted pushes count toward the limit.
  assign limit_hit = push_ok && (limit_q != 16'd0) && (captured_inc == limit_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      captured_count <= '0;
      overflow_count <= '0;
      limit_q        <= '0;
      done           <= 1'b0;
    end else if (arm_accept) begin
      captured_count <= '0;
      overflow_count <= '0;
      limit_q        <= capture_limit;
      done           <= 1'b0;
    end else begin
      if (push_ok) captured_count <= captured_inc;
      if (push_drop && (overflow_count != 16'hFFFF))
        overflow_count <= overflow_count + 16'd1;
      if ((state_q == ST_DRAIN) && fifo_empty) done <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (arm_accept) state_d = ST_ARMED;
      ST_ARMED: begin
        if (is_start)     state_d = ST_CAPTURE;
        else if (is_exit) state_d = ST_DRAIN;
      end
      // A START seen here is recorded as ordinary code and does not restart.
      ST_CAPTURE: if (is_stop || is_exit || limit_hit) state_d = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mor1kx_trace_capture_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for mor1kx_trace_capture_ctrl. Inputs change 1 time unit
// after each rising edge. Outputs are compared at that point as well. Records
// popped by the sink are logged on the falling edge. The log holds the PC and
// instruction of each record and is compared against hand-computed lists.
// ---------------------------------------------------------------------------
module tb_mor1kx_trace_capture_ctrl;

  localparam logic [31:0] START = 32'h1500_0064;
  localparam logic [31:0] STOP  = 32'h1500_00c8;
  localparam logic [31:0] EXIT0 = 32'h1500_0001;
  localparam logic [31:0] EXIT1 = 32'h1500_000c;
  localparam logic [31:0] ADDI  = 32'h9c21_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_valid;
  logic [31:0] exec_pc, exec_insn, exec_wbdata;
  logic [4:0]  exec_wbreg;
  logic        exec_wben;
  logic        arm;
  logic [15:0] capture_limit;
  logic        rec_valid, rec_ready;
  logic [31:0] rec_pc, rec_insn, rec_wbdata;
  logic [4:0]  rec_wbreg;
  logic        rec_wben;
  logic [1:0]  state;
  logic        done;
  logic [15:0] captured_count, overflow_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] log_pc[$];
  logic [31:0] log_insn[$];

  always #5 clk = ~clk;

  mor1kx_trace_capture_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .traceport_exec_valid  (exec_valid),
    .traceport_exec_pc     (exec_pc),
    .traceport_exec_insn   (exec_insn),
    .traceport_exec_wbdata (exec_wbdata),
    .traceport_exec_wbreg  (exec_wbreg),
    .traceport_exec_wben   (exec_wben),
    .arm                   (arm),
    .capture_limit         (capture_limit),
    .rec_valid             (rec_valid),
    .rec_ready             (rec_ready),
    .rec_pc                (rec_pc),
    .rec_insn              (rec_insn),
    .rec_wbdata            (rec_wbdata),
    .rec_wbreg             (rec_wbreg),
    .rec_wben              (rec_wben),
    .state                 (state),
    .done                  (done),
    .captured_count        (captured_count),
    .overflow_count        (overflow_count)
  );

  // A handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      log_pc.push_back(rec_pc);
      log_insn.push_back(rec_insn);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse(input logic [15:0] limit);
    arm = 1'b1;
    capture_limit = limit;
    tick();
    arm = 1'b0;
  endtask

  // Side fields are derived from the PC so that each record is distinct.
  task automatic retire(input logic [31:0] pc, input logic [31:0] insn);
    exec_valid  = 1'b1;
    exec_pc     = pc;
    exec_insn   = insn;
    exec_wbdata = pc ^ 32'hA5A5_0000;
    exec_wbreg  = pc[6:2];
    exec_wben   = pc[2];
    tick();
    exec_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && state != 2'd0; i++) tick();
    check(tag, {30'd0, state}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; exec_valid = 1'b0; exec_pc = '0; exec_insn = '0;
    exec_wbdata = '0; exec_wbreg = '0; exec_wben = 1'b0;
    arm = 1'b0; capture_limit = '0; rec_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // ---- Reset state ----
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_valid", {31'd0, rec_valid}, 32'd0);
    check("rst_pc", rec_pc, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cap", {16'd0, captured_count}, 32'd0);
    check("rst_ovf", {16'd0, overflow_count}, 32'd0);

    // ---- Basic window: START, 3 insns, STOP ----
    log_pc.delete(); log_insn.delete();
    arm_pulse(16'd0);
    check("t1_armed", {30'd0, state}, 32'd1);
    retire(32'h0FC, START);
    check("t1_capture", {30'd0, state}, 32'd2);
    check("t1_start_not_rec", {31'd0, rec_valid}, 32'd0);
    retire(32'h100, ADDI);
    check("t1_first_valid", {31'd0, rec_valid}, 32'd1);
    check("t1_first_pc", rec_pc, 32'h100);
    check("t1_first_wbdata", rec_wbdata, 32'hA5A5_0100);
    check("t1_first_wbreg", {27'd0, rec_wbreg}, 32'd0);
    check("t1_first_wben", {31'd0, rec_wben}, 32'd0);
    retire(32'h104, ADDI);
    retire(32'h108, ADDI);
    retire(32'h10C, STOP);
    check("t1_drain", {30'd0, state}, 32'd3);
    wait_idle("t1_idle", 10);
    check("t1_nrec", log_pc.size(), 32'd3);
    if (log_pc.size() == 3) begin
      check("t1_rec0", log_pc[0], 32'h100);
      check("t1_rec1", log_pc[1], 32'h104);
      check("t1_rec2", log_pc[2], 32'h108);
    end
    check("t1_cap", {16'd0, captured_count}, 32'd3);
    check("t1_done", {31'd0, done}, 32'd1);

    // ---- Record limit of 2 ----
    log_pc.delete(); log_insn.delete();
    arm_pulse(16'd2);
    check("t2_done_clr", {31'd0, done}, 32'd0);
    check("t2_cap_clr", {16'd0, captured_count}, 32'd0);
    retire(32'h1FC, START);
    retire(32'h200, ADDI);
    check("t2_state1", {30'd0, state}, 32'd2);
    retire(32'h204, ADDI);
    check("t2_drain", {30'd0, state}, 32'd3);
    check("t2_cap", {16'd0, captured_count}, 32'd2);
    retire(32'h208, ADDI);
    retire(32'h20C, ADDI);
    retire(32'h210, ADDI);
    wait_idle("t2_idle", 10);
    check("t2_nrec", log_pc.size(), 32'd2);
    check("t2_cap_end", {16'd0, captured_count}, 32'd2);
    check("t2_done", {31'd0, done}, 32'd1);

    // ---- Overflow: 20 insns into a 16-deep FIFO, sink stalled ----
    log_pc.delete(); log_insn.delete();
    rec_ready = 1'b0;
    arm_pulse(16'd0);
    retire(32'h2FC, START);
    for (int i = 0; i < 20; i++) retire(32'h300 + 32'(4 * i), ADDI);
    retire(32'h350, STOP);
    check("t3_drain", {30'd0, state}, 32'd3);
    check("t3_cap", {16'd0, captured_count}, 32'd16);
    check("t3_ovf", {16'd0, overflow_count}, 32'd4);
    check("t3_head", rec_pc, 32'h300);
    tick();
    check("t3_hold", rec_pc, 32'h300);
    check("t3_hold_state", {30'd0, state}, 32'd3);
    rec_ready = 1'b1;
    wait_idle("t3_idle", 40);
    check("t3_nrec", log_pc.size(), 32'd16);
    if (log_pc.size() == 16)
      for (int i = 0; i < 16; i++)
        check($sformatf("t3_rec%0d", i), log_pc[i], 32'h300 + 32'(4 * i));
    check("t3_done", {31'd0, done}, 32'd1);

    // ---- Full FIFO with a same-cycle pop accepts the push ----
    log_pc.delete(); log_insn.delete();
    rec_ready = 1'b0;
    arm_pulse(16'd0);
    retire(32'h3FC, START);
    for (int i = 0; i < 16; i++) retire(32'h400 + 32'(4 * i), ADDI);
    check("t4_ovf_pre", {16'd0, overflow_count}, 32'd0);
    rec_ready = 1'b1;
    retire(32'h440, ADDI);
    check("t4_ovf", {16'd0, overflow_count}, 32'd0);
    check("t4_cap", {16'd0, captured_count}, 32'd17);
    retire(32'h444, STOP);
    wait_idle("t4_idle", 40);
    check("t4_nrec", log_pc.size(), 32'd17);
    if (log_pc.size() == 17)
      for (int i = 0; i < 17; i++)
        check($sformatf("t4_rec%0d", i), log_pc[i], 32'h400 + 32'(4 * i));

    // ---- EXIT inside CAPTURE, plus an ignored re-arm ----
    log_pc.delete(); log_insn.delete();
    arm_pulse(16'd0);
    retire(32'h4FC, START);
    retire(32'h500, ADDI);
    arm_pulse(16'd1);
    check("t5_rearm_state", {30'd0, state}, 32'd2);
    check("t5_rearm_cap", {16'd0, captured_count}, 32'd1);
    retire(32'h504, ADDI);
    check("t5_no_limit", {30'd0, state}, 32'd2);
    retire(32'h508, EXIT0);
    check("t5_drain", {30'd0, state}, 32'd3);
    wait_idle("t5_idle", 10);
    check("t5_nrec", log_pc.size(), 32'd3);
    if (log_insn.size() == 3) begin
      check("t5_last_insn", log_insn[2], EXIT0);
      check("t5_last_pc", log_pc[2], 32'h508);
    end
    check("t5_done", {31'd0, done}, 32'd1);

    // ---- Reset in the middle of a capture window ----
    rec_ready = 1'b0;
    arm_pulse(16'd0);
    retire(32'h5FC, START);
    for (int i = 0; i < 5; i++) retire(32'h600 + 32'(4 * i), ADDI);
    check("t6_pre_valid", {31'd0, rec_valid}, 32'd1);
    check("t6_pre_cap", {16'd0, captured_count}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", {31'd0, rec_valid}, 32'd0);
    check("t6_state", {30'd0, state}, 32'd0);
    check("t6_cap", {16'd0, captured_count}, 32'd0);
    check("t6_ovf", {16'd0, overflow_count}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_pc", rec_pc, 32'd0);

    // ---- EXIT while ARMED: one cycle in DRAIN with an empty FIFO ----
    rec_ready = 1'b1;
    arm_pulse(16'd0);
    retire(32'h700, EXIT1);
    check("t7_drain", {30'd0, state}, 32'd3);
    check("t7_done_pre", {31'd0, done}, 32'd0);
    tick();
    check("t7_idle", {30'd0, state}, 32'd0);
    check("t7_done", {31'd0, done}, 32'd1);
    check("t7_cap", {16'd0, captured_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
